fetch_stage: RTL and testbench

- Instruction fetch front end. Sits directly upstream of the decode/control stage.
- Holds the PC and issues word requests to instruction memory. Buffers in-order responses in a small FIFO.
- Presents {pc, insn} pairs to decode over a valid/ready handshake.
- Accepts a redirect (taken branch/JAL/JALR, i.e. pcsel from control) that flushes everything in flight.

---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, credit-limited imem requests, in-order response buffer, redirect flush.
// Optional macro FETCH_STATS_EN adds fetch_cnt_o / flush_cnt_o event counters.
module fetch_stage #(
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = DWIDTH'(32'h0100_0000),
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_o,
  output logic [DWIDTH-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [DWIDTH-1:0] target_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [DWIDTH-1:0] pc_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 2;

  logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DWIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DWIDTH-1:0] pc_mem_q   [DEPTH];
  logic [DWIDTH-1:0] pc_mem_d   [DEPTH];
  logic [DWIDTH-1:0] insn_mem_q [DEPTH];
  logic [DWIDTH-1:0] insn_mem_d [DEPTH];

  logic              credit_ok;
  logic              accept;
  logic              resp_push;
  logic              resp_drop;
  logic              resp_any;
  logic              pop;
  logic [DWIDTH-1:0] target_aligned;

  // Drop credit counts too: flushed fetches still owe a response slot.
  assign credit_ok      = (SW'(count_q) + SW'(out_q) + SW'(drop_q)) < SW'(DEPTH);
  assign imem_req_o     = credit_ok & ~redirect_i & ~reset;
  assign imem_addr_o    = fetch_pc_q;
  assign accept         = imem_req_o & imem_ready_i;
  assign resp_drop      = imem_rvalid_i & (drop_q != '0);
  assign resp_push      = imem_rvalid_i & (drop_q == '0) & (out_q != '0);
  assign resp_any       = imem_rvalid_i & ((drop_q != '0) | (out_q != '0));
  assign valid_o        = (count_q != '0);
  assign pop            = valid_o & ready_i;
  assign insn_o         = insn_mem_q[rd_ptr_q];
  assign pc_o           = pc_mem_q[rd_ptr_q];
  assign target_aligned = {target_i[DWIDTH-1:2], 2'b00};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pc_mem_d   = pc_mem_q;
    insn_mem_d = insn_mem_q;
    if (redirect_i) begin
      // Everything still in flight becomes drop credit, less a response landing now.
      drop_d     = drop_q + out_q - CW'(resp_any);
      out_d      = '0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = target_aligned;
      resp_pc_d  = target_aligned;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + DWIDTH'(4);
      out_d  = out_q + CW'(accept) - CW'(resp_push);
      drop_d = drop_q - CW'(resp_drop);
      if (resp_push) begin
        pc_mem_d[wr_ptr_q]   = resp_pc_q;
        insn_mem_d[wr_ptr_q] = imem_rdata_i;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        resp_pc_d            = resp_pc_q + DWIDTH'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(resp_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        insn_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pc_mem_q   <= pc_mem_d;
      insn_mem_q <= insn_mem_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        resp_discard;

  assign resp_discard = resp_drop | (redirect_i & resp_push);

  // Flush count covers discarded responses plus entries cleared from the buffer.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(resp_push & ~redirect_i);
    flush_cnt_d = flush_cnt_q + 32'(resp_discard) + (redirect_i ? 32'(count_q) : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based model of fetches, in-flight slots and buffer.
module tb_fetch_stage;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0100_0000;

  typedef struct packed { logic [31:0] pc; logic [31:0] insn; } entry_t;
  typedef struct packed { logic [31:0] pc; logic drop; } flight_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  fetch_stage #(.DWIDTH(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .target_i      (target_i),
    .insn_o        (insn_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  entry_t      m_buf[$];
  flight_t     m_fl[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc;
  int          checks;
  int          failures;
  logic [31:0] cyc;
  int unsigned lat_min;
  int unsigned lat_max;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_req"}, 32'(imem_req_o), 32'd0);
    check({tag, "_pc"}, pc_o, 32'd0);
    check({tag, "_insn"}, insn_o, 32'd0);
    check({tag, "_addr"}, imem_addr_o, RST_PC);
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_fl.delete();
    mem_q.delete();
    m_pc = RST_PC;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance memory and model.
  task automatic cycle(input logic rdy, input logic mrdy, input logic redir,
                       input logic [31:0] tgt, input logic stale);
    logic        rv;
    logic [31:0] rd;
    logic        exp_req;
    flight_t     f;
    mreq_t       m;
    rv = 1'b0;
    rd = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m  = mem_q.pop_front();
      rv = 1'b1;
      rd = mem_word(m.addr);
    end else if (stale) begin
      rv = 1'b1;
      rd = 32'hDEAD_BEEF;
    end
    ready_i       = rdy;
    imem_ready_i  = mrdy;
    redirect_i    = redir;
    target_i      = tgt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    @(negedge clk);
    exp_req = (m_buf.size() + m_fl.size() < DEPTH) && !redir;
    check("req", 32'(imem_req_o), 32'(exp_req));
    check("addr", imem_addr_o, m_pc);
    check("valid", 32'(valid_o), 32'(m_buf.size() > 0));
    if (m_buf.size() > 0) begin
      check("pc", pc_o, m_buf[0].pc);
      check("insn", insn_o, m_buf[0].insn);
    end
    if (imem_req_o && mrdy)
      mem_q.push_back('{addr: imem_addr_o, due: cyc + 32'($urandom_range(lat_max, lat_min))});
    if (!redir && rdy && m_buf.size() > 0) void'(m_buf.pop_front());
    if (rv && m_fl.size() > 0) begin
      f = m_fl.pop_front();
      if (!redir && !f.drop) m_buf.push_back('{pc: f.pc, insn: rd});
    end
    if (exp_req && mrdy) begin
      m_fl.push_back('{pc: m_pc, drop: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      foreach (m_fl[i]) m_fl[i].drop = 1'b1;
      m_buf.delete();
      m_pc = {tgt[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc = cyc + 32'd1;
  endtask

  task automatic run(input int n, input logic rdy, input logic mrdy);
    for (int i = 0; i < n; i++) cycle(rdy, mrdy, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = '0;
    lat_min = 1; lat_max = 1;
    reset = 1'b1; ready_i = 1'b0; imem_ready_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = '0; redirect_i = 1'b0; target_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Streaming, 1-cycle memory, decode always ready.
    run(20, 1'b1, 1'b1);
    // Decode stalls: buffer fills to DEPTH, requests stop, head holds.
    run(10, 1'b0, 1'b1);
    run(10, 1'b1, 1'b1);
    // Memory backpressure toggling.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'(i % 2), 1'b0, 32'd0, 1'b0);

    // Redirect with two fetches outstanding at 3-cycle latency.
    lat_min = 3; lat_max = 3;
    run(10, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0100_0040, 1'b0);
    run(15, 1'b1, 1'b1);

    // Redirect to an unaligned target coinciding with a pop and a response.
    lat_min = 1; lat_max = 1;
    run(10, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0100_0043, 1'b0);
    run(10, 1'b1, 1'b1);

    // PC wrap at the top of the address space, then back-to-back redirects.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFA, 1'b0);
    run(10, 1'b1, 1'b1);
    lat_min = 3; lat_max = 3;
    run(6, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0200_0000, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0300_0010, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0100_0080, 1'b0);
    run(15, 1'b1, 1'b1);

    // Mid-operation reset with a full buffer; stale response after release is ignored.
    lat_min = 2; lat_max = 4;
    run(8, 1'b0, 1'b1);
    reset = 1'b1; imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    run(12, 1'b1, 1'b1);

    // Randomized traffic with per-block knobs.
    for (int b = 0; b < 20; b++) begin
      int unsigned pr, pm, pd;
      lat_min = 1;
      lat_max = $urandom_range(4, 1);
      pr = $urandom_range(100, 20);
      pm = $urandom_range(100, 30);
      pd = $urandom_range(8, 0);
      for (int i = 0; i < 150; i++) begin
        logic [31:0] tgt;
        tgt = ($urandom_range(9, 0) == 0) ? $urandom : RST_PC + 32'($urandom_range(255, 0));
        cycle($urandom_range(99, 0) < pr, $urandom_range(99, 0) < pm,
              $urandom_range(99, 0) < pd, tgt, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
